// File: rtl/vga_pkg.sv
// Shared VGA raster constants (default XGA 1024x768@60) used by the timing
// generator and the background/draw controllers.
package vga_pkg;

  localparam int CNT_W = 16;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam int H_ACTIVE = 1024;
  localparam int H_FP     = 24;
  localparam int H_SYNC   = 136;
  localparam int H_BP     = 160;
  localparam int V_ACTIVE = 768;
  localparam int V_FP     = 3;
  localparam int V_SYNC   = 6;
  localparam int V_BP     = 29;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic SYNC_ACTIVE = 1'b1;

  // Half-open window test [lo, hi) on a raster coordinate.
  function automatic logic in_range(cnt_t value, cnt_t lo, cnt_t hi);
    return (value >= lo) && (value < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus blanking/sync strobes decoded from the
// next count so they stay aligned with it. wrap is combinational (tick on last).
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int   ACTIVE   = H_ACTIVE,
  parameter int   FP       = H_FP,
  parameter int   SYNC     = H_SYNC,
  parameter int   BP       = H_BP,
  parameter logic SYNC_POL = SYNC_ACTIVE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  output logic [CNT_W-1:0] count,
  output logic             blnk,
  output logic             sync,
  output logic             wrap
);

  localparam cnt_t LAST    = cnt_t'(ACTIVE + FP + SYNC + BP - 1);
  localparam cnt_t BLANK   = cnt_t'(ACTIVE);
  localparam cnt_t SYNC_LO = cnt_t'(ACTIVE + FP);
  localparam cnt_t SYNC_HI = cnt_t'(ACTIVE + FP + SYNC);

  cnt_t count_next;
  logic blnk_next;
  logic sync_next;

  // >= rather than == so an out-of-range count can never run away.
  assign wrap = tick && (count >= LAST);

  always_comb begin
    count_next = count;
    if (tick) begin
      count_next = wrap ? '0 : count + cnt_t'(1);
    end
    blnk_next = (count_next >= BLANK);
    sync_next = in_range(count_next, SYNC_LO, SYNC_HI) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      blnk  <= 1'b0;
      sync  <= ~SYNC_POL;
    end else if (tick) begin
      count <= count_next;
      blnk  <= blnk_next;
      sync  <= sync_next;
    end
  end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: registered counters, sync/blank strobes and a
// frame-start pulse. Define VGA_TIMING_FRAME_CNT_EN to add the frame_cnt output.
module vga_timing
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE    = vga_pkg::H_ACTIVE,
  parameter int   H_FP        = vga_pkg::H_FP,
  parameter int   H_SYNC      = vga_pkg::H_SYNC,
  parameter int   H_BP        = vga_pkg::H_BP,
  parameter int   V_ACTIVE    = vga_pkg::V_ACTIVE,
  parameter int   V_FP        = vga_pkg::V_FP,
  parameter int   V_SYNC      = vga_pkg::V_SYNC,
  parameter int   V_BP        = vga_pkg::V_BP,
  parameter logic SYNC_ACTIVE = vga_pkg::SYNC_ACTIVE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] hcount_out,
  output logic [CNT_W-1:0] vcount_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             hblnk_out,
  output logic             vblnk_out,
  output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [CNT_W-1:0] frame_cnt
`endif
);

  logic h_wrap;
  logic v_wrap;
  logic frame_wrap;

  vga_axis_counter #(
    .ACTIVE   (H_ACTIVE),
    .FP       (H_FP),
    .SYNC     (H_SYNC),
    .BP       (H_BP),
    .SYNC_POL (SYNC_ACTIVE)
  ) u_h (
    .clk   (clk),
    .rst   (rst),
    .tick  (en),
    .count (hcount_out),
    .blnk  (hblnk_out),
    .sync  (hsync_out),
    .wrap  (h_wrap)
  );

  // Vertical axis advances only on the cycle the horizontal axis wraps.
  vga_axis_counter #(
    .ACTIVE   (V_ACTIVE),
    .FP       (V_FP),
    .SYNC     (V_SYNC),
    .BP       (V_BP),
    .SYNC_POL (SYNC_ACTIVE)
  ) u_v (
    .clk   (clk),
    .rst   (rst),
    .tick  (h_wrap),
    .count (vcount_out),
    .blnk  (vblnk_out),
    .sync  (vsync_out),
    .wrap  (v_wrap)
  );

  // h_wrap already requires en, so a held raster never pulses.
  assign frame_wrap = h_wrap && v_wrap;

  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_wrap;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_cnt <= '0;
    end else if (frame_wrap) begin
      frame_cnt <= frame_cnt + cnt_t'(1);
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing: a default XGA instance and a reduced-timing
// instance share stimulus; a per-instance model predicts every registered output.
module tb_vga_timing;

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        fs;
    logic [15:0] fc;
  } exp_t;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
  } timing_t;

  localparam logic SA = 1'b1;
  localparam int S_HA = 16, S_HF = 2, S_HS = 3, S_HB = 4;
  localparam int S_VA = 10, S_VF = 1, S_VS = 2, S_VB = 3;
  localparam int S_HTOT = S_HA + S_HF + S_HS + S_HB;  // 25
  localparam int S_VTOT = S_VA + S_VF + S_VS + S_VB;  // 16

  logic clk = 1'b0;
  logic rst;
  logic en;
  always #5 clk = ~clk;

  logic [15:0] d_h, d_v, s_h, s_v, d_fc, s_fc;
  logic d_hs, d_vs, d_hb, d_vb, d_fs;
  logic s_hs, s_vs, s_hb, s_vb, s_fs;

  vga_timing dut_d (
    .clk(clk), .rst(rst), .en(en),
    .hcount_out(d_h), .vcount_out(d_v),
    .hsync_out(d_hs), .vsync_out(d_vs),
    .hblnk_out(d_hb), .vblnk_out(d_vb),
    .frame_start(d_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(d_fc)
`endif
  );

  vga_timing #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
  ) dut_s (
    .clk(clk), .rst(rst), .en(en),
    .hcount_out(s_h), .vcount_out(s_v),
    .hsync_out(s_hs), .vsync_out(s_vs),
    .hblnk_out(s_hb), .vblnk_out(s_vb),
    .frame_start(s_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(s_fc)
`endif
  );

`ifndef VGA_TIMING_FRAME_CNT_EN
  assign d_fc = '0;
  assign s_fc = '0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int fs_cnt_s, vs_cnt_s, hs_cnt_d, hb_cnt_d;
  timing_t t_d, t_s;
  exp_t cur_d, cur_s;
  exp_t q_d[$];
  exp_t q_s[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 20) $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model_step(exp_t c, logic en_v, logic rst_v, timing_t t);
    exp_t n;
    int   htot, vtot;
    logic hw;
    htot = t.ha + t.hf + t.hs + t.hb;
    vtot = t.va + t.vf + t.vs + t.vb;
    n = c;
    if (!rst_v) begin
      n    = '0;
      n.hs = ~SA;
      n.vs = ~SA;
      return n;
    end
    if (!en_v) begin
      n.fs = 1'b0;
      return n;
    end
    hw   = (int'(c.h) == htot - 1);
    n.h  = hw ? 16'd0 : c.h + 16'd1;
    if (hw) n.v = (int'(c.v) == vtot - 1) ? 16'd0 : c.v + 16'd1;
    n.fs = hw && (int'(c.v) == vtot - 1);
    n.fc = c.fc + {15'd0, n.fs};
    n.hb = (int'(n.h) >= t.ha);
    n.hs = (int'(n.h) >= t.ha + t.hf && int'(n.h) < t.ha + t.hf + t.hs) ? SA : ~SA;
    n.vb = (int'(n.v) >= t.va);
    n.vs = (int'(n.v) >= t.va + t.vf && int'(n.v) < t.va + t.vf + t.vs) ? SA : ~SA;
    return n;
  endfunction

  task automatic cmp(string who, exp_t e, exp_t o);
    chk({who, ".hcount"}, 32'(o.h), 32'(e.h));
    chk({who, ".vcount"}, 32'(o.v), 32'(e.v));
    chk({who, ".hsync"}, 32'(o.hs), 32'(e.hs));
    chk({who, ".vsync"}, 32'(o.vs), 32'(e.vs));
    chk({who, ".hblnk"}, 32'(o.hb), 32'(e.hb));
    chk({who, ".vblnk"}, 32'(o.vb), 32'(e.vb));
    chk({who, ".frame_start"}, 32'(o.fs), 32'(e.fs));
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk({who, ".frame_cnt"}, 32'(o.fc), 32'(e.fc));
`endif
  endtask

  // Drive one clock of stimulus, predict both instances, then compare after the edge.
  task automatic cyc(logic en_v, logic rst_v);
    exp_t e;
    en  = en_v;
    rst = rst_v;
    cur_d = model_step(cur_d, en_v, rst_v, t_d);
    cur_s = model_step(cur_s, en_v, rst_v, t_s);
    q_d.push_back(cur_d);
    q_s.push_back(cur_s);
    @(negedge clk);
    if (q_d.size() == 0) chk("scoreboard_d_empty", 0, 1);
    else begin
      e = q_d.pop_front();
      cmp("dflt", e, {d_h, d_v, d_hs, d_vs, d_hb, d_vb, d_fs, d_fc});
    end
    if (q_s.size() == 0) chk("scoreboard_s_empty", 0, 1);
    else begin
      e = q_s.pop_front();
      cmp("small", e, {s_h, s_v, s_hs, s_vs, s_hb, s_vb, s_fs, s_fc});
    end
    if (s_fs) fs_cnt_s++;
    if (s_vs == SA) vs_cnt_s++;
    if (d_hs == SA) hs_cnt_d++;
    if (d_hb) hb_cnt_d++;
  endtask

  task automatic goto_small(int h, int v, string tag);
    int k;
    for (k = 0; k < 1000 && !(int'(cur_s.h) == h && int'(cur_s.v) == v); k++) cyc(1'b1, 1'b1);
    chk(tag, 32'(k < 1000), 32'd1);
  endtask

  initial begin
    t_d = '{1024, 24, 136, 160, 768, 3, 6, 29};
    t_s = '{S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB};
    cur_d = '0;
    cur_s = '0;
    en  = 1'b0;
    rst = 1'b0;

    repeat (3) cyc(1'b1, 1'b0);
    $display("phase reset: checks %0d errors %0d", n_checks, n_errors);

    fs_cnt_s = 0; vs_cnt_s = 0; hs_cnt_d = 0; hb_cnt_d = 0;
    repeat (3 * S_HTOT * S_VTOT) cyc(1'b1, 1'b1);
    chk("small_frame_pulses", 32'(fs_cnt_s), 32'd3);
    chk("small_vsync_cycles", 32'(vs_cnt_s), 32'(3 * S_VS * S_HTOT));
    repeat (2 * 1344 - 3 * S_HTOT * S_VTOT) cyc(1'b1, 1'b1);
    chk("dflt_hsync_cycles", 32'(hs_cnt_d), 32'(2 * 136));
    chk("dflt_hblnk_cycles", 32'(hb_cnt_d), 32'(2 * 320));
    $display("phase free-run: checks %0d errors %0d", n_checks, n_errors);

    goto_small(S_HTOT - 1, S_VTOT - 1, "reach_last_pixel");
    repeat (5) cyc(1'b0, 1'b1);
    chk("hold_h", 32'(s_h), 32'(S_HTOT - 1));
    chk("hold_fs", 32'(s_fs), 32'd0);
    cyc(1'b1, 1'b1);
    chk("release_fs", 32'(s_fs), 32'd1);
    chk("release_v", 32'(s_v), 32'd0);
    $display("phase en-hold: checks %0d errors %0d", n_checks, n_errors);

    repeat (600) cyc(1'($urandom_range(0, 1)), 1'b1);
    $display("phase random-en: checks %0d errors %0d", n_checks, n_errors);

    goto_small(12, 8, "reach_mid_frame");
    cyc(1'b1, 1'b0);
    chk("midrst_h", 32'(s_h), 32'd0);
    chk("midrst_v", 32'(s_v), 32'd0);
    chk("midrst_fs", 32'(s_fs), 32'd0);
    cyc(1'b1, 1'b1);
    chk("resume_h", 32'(s_h), 32'd1);
    $display("phase mid-reset: checks %0d errors %0d", n_checks, n_errors);

`ifdef VGA_TIMING_FRAME_CNT_EN
    cyc(1'b1, 1'b0);
    repeat (3 * S_HTOT * S_VTOT) cyc(1'b1, 1'b1);
    chk("frame_cnt_3", 32'(s_fc), 32'd3);
    $display("phase frame-cnt: checks %0d errors %0d", n_checks, n_errors);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
